// File: rtl/ysyx_22041412_sram_hs.sv
// Single-port SRAM behind a valid/ready request/response handshake with a fixed
// accept-to-response latency, RISC-V sized loads/stores and fault reporting.
module ysyx_22041412_sram_hs #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DATA_DEPTH = 65536,
  parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
  parameter int unsigned LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wen,
  input  logic [2:0]            req_func3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err
);

  localparam int unsigned NB   = DATA_WIDTH / 8;
  localparam int unsigned OFFW = $clog2(NB);
  localparam int unsigned IDXW = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE_A  = BASE_ADDR[ADDR_WIDTH-1:0];
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DATA_DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_func3;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_err;
  logic                  r_load_ok;

  logic                  w_accept;
  logic                  w_enter_resp;
  logic                  w_mem_en;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [2:0]            w_func3;
  logic                  w_wen;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic [ADDR_WIDTH-1:0] w_rel;
  logic [ADDR_WIDTH-1:0] w_word;
  logic [IDXW-1:0]       w_idx;
  logic [OFFW-1:0]       w_off;
  logic                  w_misalign;
  logic                  w_err;
  logic [7:0]            w_mask8;
  logic [NB-1:0]         w_mask;
  logic [DATA_WIDTH-1:0] w_wdata_sh;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [DATA_WIDTH-1:0] w_ld_sh;
  logic [DATA_WIDTH-1:0] w_keep;
  logic [7:0]            w_nbits;
  logic                  w_sign;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (req_valid) w_state_next = (LATENCY == 1) ? S_RESP : S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_next = S_RESP;
      S_RESP:  if (resp_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from state only
  always_comb begin
    req_ready  = (r_state == S_IDLE);
    resp_valid = (r_state == S_RESP);
  end

  assign w_accept     = (r_state == S_IDLE) && req_valid;
  assign w_enter_resp = (w_state_next == S_RESP) && (r_state != S_RESP);
  assign w_mem_en     = w_enter_resp && !rst;

  // With LATENCY=1 the array is accessed on the accept edge, before capture lands
  assign w_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
  assign w_func3 = (r_state == S_IDLE) ? req_func3 : r_func3;
  assign w_wen   = (r_state == S_IDLE) ? req_wen   : r_wen;
  assign w_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;

  assign w_rel  = w_addr - BASE_A;
  assign w_word = w_rel >> OFFW;
  assign w_idx  = w_word[IDXW-1:0];
  assign w_off  = w_addr[OFFW-1:0];

  always_comb begin
    w_misalign = 1'b0;
    w_mask8    = 8'hFF;
    unique case (w_func3[1:0])
      2'b00: begin w_misalign = 1'b0;           w_mask8 = 8'h01; end
      2'b01: begin w_misalign = w_addr[0];      w_mask8 = 8'h03; end
      2'b10: begin w_misalign = |w_addr[1:0];   w_mask8 = 8'h0F; end
      default: begin w_misalign = |w_addr[2:0]; w_mask8 = 8'hFF; end
    endcase
  end

  assign w_err = w_misalign
               | (w_addr < BASE_A)
               | (w_word >= DEPTH_A)
               | (w_func3 == 3'b111)
               | (w_wen && w_func3[2])
               | ((DATA_WIDTH == 32) && (w_func3[1:0] == 2'b11));

  assign w_mask     = w_mask8[NB-1:0] << w_off;
  assign w_wdata_sh = w_wdata << {w_off, 3'b000};
  assign w_wr_en    = w_wen && !w_err;

  // One byte-wide array per lane so the byte mask maps onto independent RAMs
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] r_mem [DATA_DEPTH];
      logic [7:0] r_rd_byte;
      always_ff @(posedge clk) begin
        if (w_mem_en) begin
          r_rd_byte <= r_mem[w_idx];
          if (w_wr_en && w_mask[gi]) r_mem[w_idx] <= w_wdata_sh[gi*8 +: 8];
        end
      end
      assign w_rd_word[gi*8 +: 8] = r_rd_byte;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_addr    <= '0;
      r_func3   <= 3'd0;
      r_wen     <= 1'b0;
      r_wdata   <= '0;
      r_err     <= 1'b0;
      r_load_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr  <= req_addr;
        r_func3 <= req_func3;
        r_wen   <= req_wen;
        r_wdata <= req_wdata;
        r_cnt   <= CNT_INIT;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) begin
        r_err     <= w_err;
        r_load_ok <= !w_err && !w_wen;
      end
    end
  end

  // Load extraction: keep mask covers the access size, its top bit is the sign
  always_comb begin
    w_ld_sh    = w_rd_word >> {r_addr[OFFW-1:0], 3'b000};
    w_nbits    = 8'd8 << r_func3[1:0];
    w_keep     = ~({DATA_WIDTH{1'b1}} << w_nbits);
    w_sign     = !r_func3[2] && (|(w_ld_sh & (w_keep ^ (w_keep >> 1))));
    resp_rdata = '0;
    if (r_load_ok) resp_rdata = (w_ld_sh & w_keep) | (w_sign ? ~w_keep : '0);
  end

  assign resp_err = r_err;

endmodule
